r4_sdf_stage_param: RTL and testbench



---
 rtl/r4_sdf_stage_param.sv | 191 +++++++++++++++++++
 tb/tb_r4_sdf_stage_param.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r4_sdf_stage_param.sv
// Radix-4 single-delay-feedback butterfly stage: FFT/IFFT select, optional /4 scaling
// with saturation, valid/ready stalling, self-draining flush and twiddle exponent output.
module r4_sdf_stage_param #(
    parameter int WIDTH  = 16,
    parameter int STRIDE = 16,
    parameter int GROW   = 1,
    parameter int TW     = $clog2(STRIDE) + 2,
    localparam int OW    = (GROW != 0) ? WIDTH + 2 : WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_r,
    input  logic signed [WIDTH-1:0] in_i,
    input  logic                    in_last,
    input  logic                    inv,
    output logic                    out_valid,
    output logic signed [OW-1:0]    out_r,
    output logic signed [OW-1:0]    out_i,
    output logic [TW-1:0]           out_tw,
    output logic                    out_last
);

    localparam int IW = WIDTH + 2;
    localparam int XW = $clog2(STRIDE);
    localparam logic signed [IW-2:0] QMAX = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic signed [IW-2:0] QMIN = {2'b11, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_BFLY, S_OVLP, S_DRAIN} state_t;

    state_t            r_state;
    logic [XW-1:0]     r_idx;
    logic [1:0]        r_phase;
    logic              r_inv;
    logic signed [IW-1:0] r_dR [3][STRIDE];
    logic signed [IW-1:0] r_dI [3][STRIDE];

    logic              w_accept;
    logic              w_drain;
    logic              w_step;
    logic              w_idxLast;
    logic              w_grpEnd;
    logic [1:0]        w_rsel;
    logic [TW-1:0]     w_grp;
    logic [TW-1:0]     w_tw;
    logic signed [IW-1:0] w_inR, w_inI, w_rdR, w_rdI;
    logic signed [IW-1:0] w_x0r, w_x0i, w_x1r, w_x1i, w_x2r, w_x2i;
    logic signed [IW-1:0] w_ar, w_ai, w_br, w_bi, w_cr, w_ci, w_dr, w_di;
    logic signed [IW-1:0] w_y0r, w_y0i, w_y1r, w_y1i, w_y2r, w_y2i, w_y3r, w_y3i;

    // Round-half-up divide by 4 with saturation; full precision passes straight through.
    function automatic logic signed [OW-1:0] fmt(input logic signed [IW-1:0] y);
        logic signed [IW:0]      rnd;
        logic signed [IW-2:0]    q;
        logic signed [WIDTH-1:0] s;
        rnd = {y[IW-1], y} + (IW+1)'(2);
        q   = rnd[IW:2];
        if (q > QMAX)
            s = {1'b0, {(WIDTH-1){1'b1}}};
        else if (q < QMIN)
            s = {1'b1, {(WIDTH-1){1'b0}}};
        else
            s = q[WIDTH-1:0];
        if (GROW != 0)
            fmt = OW'(y);
        else
            fmt = OW'(s);
    endfunction

    assign in_ready  = (r_state != S_DRAIN);
    assign w_accept  = in_valid & in_ready;
    assign w_drain   = (r_state == S_DRAIN);
    assign w_step    = w_accept | w_drain;
    assign w_idxLast = (r_idx == XW'(STRIDE - 1));
    assign w_grpEnd  = (r_phase == 2'd2) && w_idxLast;
    assign w_rsel    = (r_phase == 2'd3) ? 2'd0 : r_phase;
    assign w_grp     = TW'(r_phase) + TW'(1);
    assign w_tw      = w_grp * TW'(r_idx);

    assign w_inR = {{2{in_r[WIDTH-1]}}, in_r};
    assign w_inI = {{2{in_i[WIDTH-1]}}, in_i};
    assign w_rdR = r_dR[w_rsel][r_idx];
    assign w_rdI = r_dI[w_rsel][r_idx];

    assign w_x0r = r_dR[0][r_idx];
    assign w_x0i = r_dI[0][r_idx];
    assign w_x1r = r_dR[1][r_idx];
    assign w_x1i = r_dI[1][r_idx];
    assign w_x2r = r_dR[2][r_idx];
    assign w_x2i = r_dI[2][r_idx];

    assign w_ar = w_x0r + w_x2r;
    assign w_ai = w_x0i + w_x2i;
    assign w_br = w_x1r + w_inR;
    assign w_bi = w_x1i + w_inI;
    assign w_cr = w_x0r - w_x2r;
    assign w_ci = w_x0i - w_x2i;
    assign w_dr = w_x1r - w_inR;
    assign w_di = w_x1i - w_inI;

    // Forward: y1 = C - jD = (Cr + Di, Ci - Dr); inverse swaps the sign of j.
    assign w_y0r = w_ar + w_br;
    assign w_y0i = w_ai + w_bi;
    assign w_y2r = w_ar - w_br;
    assign w_y2i = w_ai - w_bi;
    assign w_y1r = r_inv ? (w_cr - w_di) : (w_cr + w_di);
    assign w_y1i = r_inv ? (w_ci + w_dr) : (w_ci - w_dr);
    assign w_y3r = r_inv ? (w_cr + w_di) : (w_cr - w_di);
    assign w_y3i = r_inv ? (w_ci - w_dr) : (w_ci + w_dr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_phase   <= 2'd0;
            r_inv     <= 1'b0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_i     <= '0;
            out_tw    <= '0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (w_step) begin
                if (w_idxLast) begin
                    r_idx   <= '0;
                    r_phase <= r_phase + 2'd1;
                end else begin
                    r_idx <= r_idx + XW'(1);
                end
                if (w_accept && (r_phase == 2'd0) && (r_idx == '0))
                    r_inv <= inv;
                case (r_state)
                    S_IDLE: r_state <= S_FILL;
                    S_FILL: begin
                        if (w_grpEnd)
                            r_state <= S_BFLY;
                    end
                    S_BFLY: begin
                        out_valid <= 1'b1;
                        out_r     <= fmt(w_y0r);
                        out_i     <= fmt(w_y0i);
                        out_tw    <= '0;
                        if (w_idxLast)
                            r_state <= in_last ? S_DRAIN : S_OVLP;
                    end
                    S_OVLP: begin
                        out_valid <= 1'b1;
                        out_r     <= fmt(w_rdR);
                        out_i     <= fmt(w_rdI);
                        out_tw    <= w_tw;
                        if (w_grpEnd)
                            r_state <= S_BFLY;
                    end
                    S_DRAIN: begin
                        out_valid <= 1'b1;
                        out_r     <= fmt(w_rdR);
                        out_i     <= fmt(w_rdI);
                        out_tw    <= w_tw;
                        if (w_grpEnd) begin
                            r_state  <= S_IDLE;
                            r_phase  <= 2'd0;
                            out_last <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Pending results reuse the slot whose value was just read out for emission.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (r_phase == 2'd3) begin
                r_dR[0][r_idx] <= w_y1r;
                r_dI[0][r_idx] <= w_y1i;
                r_dR[1][r_idx] <= w_y2r;
                r_dI[1][r_idx] <= w_y2i;
                r_dR[2][r_idx] <= w_y3r;
                r_dI[2][r_idx] <= w_y3i;
            end else begin
                r_dR[w_rsel][r_idx] <= w_inR;
                r_dI[w_rsel][r_idx] <= w_inI;
            end
        end
    end

endmodule

// File: tb/tb_r4_sdf_stage_param.sv
// Scoreboard bench for r4_sdf_stage_param: a full-precision and a scaled instance share
// one stimulus stream; expected outputs come from a direct 4-point DFT reference.
module tb_r4_sdf_stage_param;

    localparam int S = 4;
    localparam int N = 4 * S;

    typedef struct {
        int r;
        int i;
        int sr;
        int si;
        int tw;
        int last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_last;
    logic inv;
    logic signed [15:0] in_r;
    logic signed [15:0] in_i;
    logic inReadyG, inReadyS, outValidG, outValidS, outLastG, outLastS;
    logic signed [17:0] outRG, outIG;
    logic signed [15:0] outRS, outIS;
    logic [3:0] outTwG, outTwS;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int blkR[N];
    int blkI[N];
    bit prevLast = 1'b0;
    bit prevAcc = 1'b0;
    bit prevReady = 1'b1;

    always #5 clk = ~clk;

    r4_sdf_stage_param #(.WIDTH(16), .STRIDE(S), .GROW(1)) dutG (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReadyG),
        .in_r(in_r), .in_i(in_i), .in_last(in_last), .inv(inv),
        .out_valid(outValidG), .out_r(outRG), .out_i(outIG),
        .out_tw(outTwG), .out_last(outLastG)
    );

    r4_sdf_stage_param #(.WIDTH(16), .STRIDE(S), .GROW(0)) dutS (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReadyS),
        .in_r(in_r), .in_i(in_i), .in_last(in_last), .inv(inv),
        .out_valid(outValidS), .out_r(outRS), .out_i(outIS),
        .out_tw(outTwS), .out_last(outLastS)
    );

    task automatic checkOutput(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic int sat4(input int y);
        int t;
        t = (y + 2) >>> 2;
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
        return t;
    endfunction

    // Multiply (a + jb) by (-j)^e.
    task automatic rot(input int a, input int b, input int e, output int ro, output int io);
        case (e)
            0: begin ro = a;  io = b;  end
            1: begin ro = b;  io = -a; end
            2: begin ro = -a; io = -b; end
            default: begin ro = -b; io = a; end
        endcase
    endtask

    // Outputs leave in order y0[0..S-1], y1[..], y2[..], y3[..] for each block.
    task automatic pushBlock(input bit invMode, input bit last);
        exp_t e;
        int tr, ti, ex;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < S; k++) begin
                e.r = 0;
                e.i = 0;
                for (int m = 0; m < 4; m++) begin
                    ex = (p * m) % 4;
                    if (invMode) ex = (4 - ex) % 4;
                    rot(blkR[m*S+k], blkI[m*S+k], ex, tr, ti);
                    e.r += tr;
                    e.i += ti;
                end
                e.sr = sat4(e.r);
                e.si = sat4(e.i);
                e.tw = p * k;
                e.last = (last && p == 3 && k == S - 1) ? 1 : 0;
                q.push_back(e);
            end
        end
    endtask

    task automatic sendSample(input int r, input int i, input bit lst, input bit iv,
                              output int waited, output int lastSeen);
        bit got;
        got = 1'b0;
        waited = 0;
        lastSeen = 0;
        in_r = 16'(r);
        in_i = 16'(i);
        in_last = lst;
        inv = iv;
        in_valid = 1'b1;
        while (!got && waited <= 200) begin
            @(negedge clk);
            if (inReadyG) begin
                got = 1'b1;
                lastSeen = outLastG ? 1 : 0;
            end else begin
                waited++;
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: got no in_ready, expected in_ready within 200 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic applyStimulus(input bit invMode, input bit last, input bit stall);
        int waited, lastSeen;
        bit iv, lst;
        pushBlock(invMode, last);
        for (int n = 0; n < N; n++) begin
            if (stall && n > 0) begin
                @(posedge clk);
                #1;
            end
            iv = (n == 0) ? invMode : !invMode;
            lst = (n == N - 1) ? last : (n % 5 == 2);
            sendSample(blkR[n], blkI[n], lst, iv, waited, lastSeen);
            if (n == 0 && prevLast) begin
                checkOutput("drain_ready_low_cycles", waited, 3 * S);
                checkOutput("accept_at_out_last", lastSeen, 1);
            end
        end
        prevLast = last;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_in_ready"}, int'(inReadyG), 1);
        checkOutput({tag, "_out_valid"}, int'(outValidG), 0);
        checkOutput({tag, "_out_r"}, int'(outRG), 0);
        checkOutput({tag, "_out_i"}, int'(outIG), 0);
        checkOutput({tag, "_out_tw"}, int'(outTwG), 0);
        checkOutput({tag, "_out_last"}, int'(outLastG), 0);
        checkOutput({tag, "_in_ready_s"}, int'(inReadyS), 1);
        checkOutput({tag, "_out_valid_s"}, int'(outValidS), 0);
        checkOutput({tag, "_out_r_s"}, int'(outRS), 0);
    endtask

    task automatic fillRamp(input int seed);
        for (int n = 0; n < N; n++) begin
            blkR[n] = 13 * n - 90 + seed;
            blkI[n] = 50 - 7 * n + 3 * seed;
        end
    endtask

    task automatic fillDc();
        for (int n = 0; n < N; n++) begin
            blkR[n] = 100;
            blkI[n] = 0;
        end
    endtask

    task automatic fillDirection();
        for (int n = 0; n < N; n++) begin
            blkR[n] = 0;
            blkI[n] = (n >= S && n < 2 * S) ? 100 : 0;
        end
    endtask

    // Monitor: pops one expected entry per presented output.
    always @(negedge clk) begin
        exp_t e;
        if (outValidG || outValidS) begin
            checkOutput("out_valid_g", int'(outValidG), 1);
            checkOutput("out_valid_s", int'(outValidS), 1);
            checkOutput("out_valid_timing", (prevAcc || !prevReady) ? 1 : 0, 1);
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_output: got out_valid with r=%0d, expected no output",
                         outRG);
            end else begin
                e = q.pop_front();
                checkOutput("out_r", int'(outRG), e.r);
                checkOutput("out_i", int'(outIG), e.i);
                checkOutput("out_r_scaled", int'(outRS), e.sr);
                checkOutput("out_i_scaled", int'(outIS), e.si);
                checkOutput("out_tw", int'(outTwG), e.tw);
                checkOutput("out_tw_scaled", int'(outTwS), e.tw);
                checkOutput("out_last", int'(outLastG), e.last);
                checkOutput("out_last_scaled", int'(outLastS), e.last);
            end
        end
        prevAcc = in_valid && inReadyG;
        prevReady = inReadyG;
    end

    initial begin
        int waited, lastSeen;
        rst = 1'b1;
        in_valid = 1'b0;
        in_r = '0;
        in_i = '0;
        in_last = 1'b0;
        inv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkReset("reset");
        rst = 1'b0;

        // Reset in the middle of an overlapped block discards everything pending.
        fillRamp(0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        sendSample(5, -5, 1'b0, 1'b0, waited, lastSeen);
        sendSample(6, -6, 1'b0, 1'b0, waited, lastSeen);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        rst = 1'b0;
        prevLast = 1'b0;
        checkReset("mid_reset");
        for (int n = 0; n < 3 * S; n++) begin
            sendSample(n + 1, -n, 1'b1, 1'b0, waited, lastSeen);
            checkOutput("fill_no_out_valid", int'(outValidG), 0);
            checkOutput("fill_no_out_valid_s", int'(outValidS), 0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        fillDc();
        applyStimulus(1'b0, 1'b1, 1'b0);
        fillDirection();
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);

        for (int k = 0; k < S; k++) begin
            blkR[k] = 32767;      blkI[k] = 0;
            blkR[S+k] = 0;        blkI[S+k] = 32767;
            blkR[2*S+k] = -32768; blkI[2*S+k] = 0;
            blkR[3*S+k] = 0;      blkI[3*S+k] = -32768;
        end
        applyStimulus(1'b0, 1'b1, 1'b0);

        fillDc();
        applyStimulus(1'b0, 1'b1, 1'b1);
        fillDirection();
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);

        fillRamp(11);
        applyStimulus(1'b0, 1'b0, 1'b0);
        fillRamp(-40);
        applyStimulus(1'b1, 1'b0, 1'b0);
        fillRamp(77);
        applyStimulus(1'b0, 1'b1, 1'b0);
        fillRamp(3);
        applyStimulus(1'b1, 1'b1, 1'b0);

        repeat (3 * S + 6) @(posedge clk);
        #1;
        checkOutput("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
